// File: rtl/pll_reset_sequencer_if.sv
// Lock/reset handshake between the PLL reset sequencer and the rest of the system.
// master = the sequencer, slave = whoever drives lock and consumes the resets.
interface pll_reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             locked;
    logic             clr_cnt;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    modport master (
        input  locked,
        input  clr_cnt,
        output pll_rst,
        output sys_rst,
        output ready,
        output lock_loss_cnt,
        output timeout_cnt
    );

    modport slave (
        output locked,
        output clr_cnt,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  lock_loss_cnt,
        input  timeout_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for and qualifies lock, then releases the system reset.
// Loss of lock while running restarts the whole sequence and is counted.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int STABLE_CYCLES = 256,
    parameter int CNT_W         = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]    RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    STB_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [1:0]       sync_q;
    logic             lk_s;
    logic             to_evt;
    logic             loss_evt;
    logic             pll_rst_q;
    logic             sys_rst_q;
    logic             ready_q;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    // locked is asynchronous to refclk; only the second stage is ever used
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.locked};
        end
    end

    assign lk_s = sync_q[1];

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        to_evt   = 1'b0;
        loss_evt = 1'b0;
        case (state_q)
            HOLD: begin
                if (tmr_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // lock seen in the last waiting cycle still counts as a lock
                if (lk_s) begin
                    state_d = STABLE;
                    tmr_d   = '0;
                end else if (tmr_q == TO_LAST) begin
                    state_d = HOLD;
                    tmr_d   = '0;
                    to_evt  = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    tmr_d   = '0;
                end else if (tmr_q == STB_LAST) begin
                    state_d = RUN;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d  = HOLD;
                    tmr_d    = '0;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                tmr_d   = '0;
            end
        endcase
    end

    // a clear in the same cycle as an event wins over the increment
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        to_cnt_d   = to_cnt_q;
        if (bus.clr_cnt) begin
            loss_cnt_d = '0;
            to_cnt_d   = '0;
        end else begin
            if (loss_evt && (loss_cnt_q != CNT_MAX)) begin
                loss_cnt_d = loss_cnt_q + 1'b1;
            end
            if (to_evt && (to_cnt_q != CNT_MAX)) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= HOLD;
            tmr_q      <= '0;
            pll_rst_q  <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            loss_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pll_rst_q  <= (state_d == HOLD);
            sys_rst_q  <= (state_d != RUN);
            ready_q    <= (state_d == RUN);
            loss_cnt_q <= loss_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst       = sys_rst_q;
    assign bus.ready         = ready_q;
    assign bus.lock_loss_cnt = loss_cnt_q;
    assign bus.timeout_cnt   = to_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: each run derives the expected output-change timeline from a
// random lock waveform, and a monitor matches every observed output change against it.
module tb_pll_reset_sequencer;
    localparam int RST  = 16;
    localparam int TO   = 40;
    localparam int STB  = 24;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MAXN = 800;
    localparam int NRUN = 8;
    localparam logic [6:0] RST_VAL = 7'b1100000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pll_reset_sequencer_if #(.CNT_W(CW)) bus_if ();

    pll_reset_sequencer #(
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(STB),
        .CNT_W        (CW)
    ) dut (
        .refclk(clk),
        .rst   (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [6:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         base  = 0;
    int         cur_run = 0;
    bit         run_active = 0;
    logic [6:0] prev_obs = RST_VAL;
    int         n = 0;

    bit L      [0:MAXN+2];
    bit C      [0:MAXN+2];
    bit e_pll  [0:MAXN];
    bit e_sys  [0:MAXN];
    bit e_rdy  [0:MAXN];
    bit inc_to [0:MAXN];
    bit inc_ll [0:MAXN];

    always @(posedge clk) cyc <= cyc + 1;

    // Lock as seen by the decision made at edge e: locked driven after edge e-3.
    function automatic bit lk(input int e);
        return (e >= 3 && e <= n) ? L[e-3] : 1'b0;
    endfunction

    function automatic int first_hit(input int p, input int lim, input bit want);
        for (int k = 1; k <= lim; k++) begin
            if (lk(p + k) == want) return k;
        end
        return 0;
    endfunction

    task automatic fill(input int a, input int b, input bit p, input bit s, input bit r);
        for (int e = (a < 0 ? 0 : a); e <= b && e <= n; e++) begin
            e_pll[e] = p;
            e_sys[e] = s;
            e_rdy[e] = r;
        end
    endtask

    // Walk the lock timeline phase by phase: reset pulse, wait window, stability window, run.
    task automatic model_phases();
        int t, w, s, r, k, next_hold;
        for (int e = 0; e <= MAXN; e++) begin
            e_pll[e] = 1; e_sys[e] = 1; e_rdy[e] = 0; inc_to[e] = 0; inc_ll[e] = 0;
        end
        t = 0;
        while (t <= n) begin
            w = t + RST;
            fill(t, w - 1, 1, 1, 0);
            next_hold = -1;
            while (w <= n && next_hold < 0) begin
                k = first_hit(w, TO, 1'b1);
                if (k == 0) begin
                    fill(w, w + TO - 1, 0, 1, 0);
                    if (w + TO <= n) inc_to[w + TO] = 1;
                    next_hold = w + TO;
                end else begin
                    s = w + k;
                    fill(w, s - 1, 0, 1, 0);
                    k = first_hit(s, STB, 1'b0);
                    if (k != 0) begin
                        fill(s, s + k - 1, 0, 1, 0);
                        w = s + k;
                    end else begin
                        r = s + STB;
                        fill(s, r - 1, 0, 1, 0);
                        k = first_hit(r, MAXN + 2, 1'b0);
                        fill(r, r + k - 1, 0, 0, 1);
                        if (r + k <= n) inc_ll[r + k] = 1;
                        next_hold = r + k;
                    end
                end
            end
            if (next_hold < 0) break;
            t = next_hold;
        end
    endtask

    task automatic model_counters();
        int llc, toc;
        logic [6:0] prev, cur;
        ev_t ev;
        llc = 0; toc = 0; prev = RST_VAL;
        for (int e = 1; e <= n; e++) begin
            if (C[e]) begin
                llc = 0; toc = 0;
            end else begin
                if (inc_ll[e] && llc < CMAX) llc++;
                if (inc_to[e] && toc < CMAX) toc++;
            end
            cur = {e_pll[e], e_sys[e], e_rdy[e], CW'(llc), CW'(toc)};
            if (cur != prev) begin
                ev.cyc = e;
                ev.val = cur;
                exp_q.push_back(ev);
            end
            prev = cur;
        end
    endtask

    task automatic build(input int kind);
        int t1, t2, len, lvl, e, nto;
        for (int i = 0; i <= MAXN + 2; i++) begin L[i] = 0; C[i] = 0; end
        case (kind)
            0: begin  // nominal lock, run ends in the stability window
                n = 45;
                for (int i = 30; i <= n; i++) L[i] = 1;
            end
            1: begin  // lock, run, lose lock, relock
                t1  = $urandom_range(20, 60);
                t2  = t1 + 3 + STB + $urandom_range(10, 30);
                len = $urandom_range(3, 30);
                n   = t2 + len + RST + STB + 40;
                for (int i = t1; i <= n; i++) L[i] = (i < t2 || i >= t2 + len);
            end
            2: begin  // repeated timeouts, saturation, clear against a timeout
                t1 = 6 * (RST + TO) + $urandom_range(10, 40);
                n  = t1 + 3 + STB + 30;
                for (int i = t1; i <= n; i++) L[i] = 1;
            end
            4: begin  // 3-cycle glitch inside the stability window
                t1 = $urandom_range(20, 30);
                n  = t1 + 2 * STB + 60;
                for (int i = t1; i <= n; i++) L[i] = !(i >= t1 + STB / 2 && i < t1 + STB / 2 + 3);
            end
            default: begin  // random lock waveform with occasional clears
                n = 600;
                e = 0;
                while (e <= n) begin
                    lvl = $urandom_range(0, 1);
                    if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 4);
                    else len = lvl ? $urandom_range(20, 120) : $urandom_range(10, 70);
                    for (int i = e; i < e + len && i <= n; i++) L[i] = lvl[0];
                    e += len;
                end
                for (int i = 1; i <= n; i++) C[i] = ($urandom_range(0, 149) == 0);
            end
        endcase
        model_phases();
        if (kind == 2) begin
            nto = 0;
            for (int i = 1; i <= n; i++) begin
                if (inc_to[i]) begin
                    nto++;
                    if (nto == 6) C[i] = 1;
                end
            end
        end
        model_counters();
    endtask

    task automatic check_reset(input int r);
        logic [6:0] got;
        got = {bus_if.pll_rst, bus_if.sys_rst, bus_if.ready, bus_if.lock_loss_cnt, bus_if.timeout_cnt};
        total++;
        if (got !== RST_VAL) begin
            bad++;
            $display("FAIL reset_values run=%0d got=%b want=%b", r, got, RST_VAL);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] cur;
        ev_t ev;
        if (run_active) begin
            cur = {bus_if.pll_rst, bus_if.sys_rst, bus_if.ready, bus_if.lock_loss_cnt, bus_if.timeout_cnt};
            if (cur !== prev_obs) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change run=%0d edge=%0d got=%b want=no change", cur_run, cyc - base, cur);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.cyc != cyc - base || ev.val !== cur) begin
                        bad++;
                        $display("FAIL out_change run=%0d got=%b@edge%0d want=%b@edge%0d",
                                 cur_run, cur, cyc - base, ev.val, ev.cyc);
                    end else begin
                        $display("run %0d edge %4d pll=%b sys=%b rdy=%b lloss=%0d tout=%0d ok",
                                 cur_run, ev.cyc, cur[6], cur[5], cur[4], cur[3:2], cur[1:0]);
                    end
                end
                prev_obs = cur;
            end
        end
    end

    int kinds [0:NRUN-1] = '{0, 1, 4, 2, 3, 3, 1, 3};

    initial begin
        bus_if.locked  = 1'b0;
        bus_if.clr_cnt = 1'b0;
        #2;
        for (int r = 0; r < NRUN; r++) begin
            rst = 1'b1;
            #1;
            check_reset(r);
            cur_run = r;
            build(kinds[r]);
            repeat (2) @(posedge clk);
            #2;
            rst            = 1'b0;
            bus_if.locked  = L[0];
            bus_if.clr_cnt = C[1];
            base           = cyc;
            prev_obs       = RST_VAL;
            run_active     = 1'b1;
            for (int e = 1; e <= n; e++) begin
                @(posedge clk);
                #1;
                bus_if.locked  = L[e];
                bus_if.clr_cnt = C[e + 1];
            end
            @(negedge clk);
            #2;
            run_active = 1'b0;
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL missing_changes run=%0d got=%0d unseen want=0 unseen, next at edge %0d",
                         r, exp_q.size(), exp_q[0].cyc);
                exp_q.delete();
            end
        end
        rst = 1'b1;
        #1;
        check_reset(NRUN);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controller on the other end of the PLL rst/locked interface: drives the PLL reset, watches the lock indication, and releases the downstream system reset.
- Runs in the 50 MHz reference clock domain.
- Pulses the PLL reset for a fixed period, waits (with timeout and retry) for lock, qualifies lock for a stability window, then deasserts the system reset.
- On loss of lock it re-asserts the system reset, counts the event and restarts the sequence.

Parameters:
- RST_CYCLES, 16, cycles the PLL reset output is held high per attempt (>=1)
- LOCK_TIMEOUT, 1000, cycles to wait for synchronized lock before retrying (>=1)
- STABLE_CYCLES, 256, consecutive synchronized-lock cycles required before release (>=1)
- CNT_W, 8, width of the lock-loss and timeout event counters

Ports:
- refclk  input  1  reference clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- locked  input  1  PLL lock indication; asynchronous to refclk
- pll_rst  output  1  reset to the PLL, active-high
- sys_rst  output  1  downstream system reset, active-high
- ready  output  1  high only in RUN state
- lock_loss_cnt  output  CNT_W  number of RUN->lock-lost events; saturating
- timeout_cnt  output  CNT_W  number of WAIT_LOCK timeouts; saturating
- clr_cnt  input  1  synchronous clear of both counters

Behaviour:
- Interface rule (already decided): one clock; reset is asynchronous and active-high, on ports refclk and rst.
- locked passes through a 2-flop synchronizer (lk_s). All decisions use lk_s, so raw-to-decision latency is 2 cycles.
- Synchronizer flops reset to 0.
- While rst is high: state=HOLD, pll_rst=1, sys_rst=1, ready=0, both counters=0, internal counter=0.
- State HOLD:
  - pll_rst=1, sys_rst=1.
  - Counter increments each cycle. When it reaches RST_CYCLES-1: go to WAIT_LOCK and clear the counter.
  - pll_rst is therefore high for exactly RST_CYCLES cycles after rst release.
- State WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If lk_s=1: go to STABLE and clear the counter.
  - Else if counter = LOCK_TIMEOUT-1: increment timeout_cnt (saturating), go to HOLD, clear the counter.
  - Else increment the counter.
  - If lk_s=1 in the timeout cycle, the lock wins: go to STABLE, no timeout counted.
- State STABLE:
  - pll_rst=0, sys_rst=1.
  - If lk_s=0: go back to WAIT_LOCK and clear the counter. This is a glitch, not counted.
  - Else if counter = STABLE_CYCLES-1: go to RUN.
  - Else increment the counter.
- State RUN:
  - pll_rst=0, sys_rst=0, ready=1.
  - If lk_s=0: go to HOLD, clear the counter, increment lock_loss_cnt (saturating).
  - The exit is registered: sys_rst goes high on the clock edge after lk_s falls.
- Outputs pll_rst, sys_rst and ready are registered and decoded from the registered state. No combinational path from locked to any output.
- Counters:
  - Saturate at 2^CNT_W-1, no wrap.
  - clr_cnt clears both on the next edge. clr_cnt takes priority over an increment in the same cycle.
- Internal counter width is clog2 of the max of the three cycle parameters. It never exceeds its terminal value.
- Reset asserted mid-sequence: immediate asynchronous return to the reset values above. Release restarts at HOLD with a full RST_CYCLES pulse.
- Reset deassertion is not synchronized internally; the top level supplies a synchronized rst release.

Test Plan:
- Nominal lock (defaults): release rst; locked=1 at cycle 30 -> pll_rst high for cycles 0-15; ready rises at cycle 30+2+256 (+/-1 registration); sys_rst=0 thereafter; both counters 0.
- Timeout retry (LOCK_TIMEOUT=1000): locked held 0 -> pll_rst re-pulses for 16 cycles every 1016 cycles; timeout_cnt increments 1,2,3. Assert locked -> normal release, timeout_cnt frozen.
- Glitch in STABLE: lock, then drop locked for 3 cycles at stable count 100 -> stays sys_rst=1, no pll_rst pulse, lock_loss_cnt=0; the full 256-cycle stability window restarts after relock.
- Loss in RUN: drop locked while ready=1 -> sys_rst=1 within 3 cycles of the locked fall; pll_rst 16-cycle pulse follows; lock_loss_cnt=1; ready returns after relock+256.
- Saturation/clear (CNT_W=2): force 5 timeouts -> timeout_cnt=3; pulse clr_cnt in the same cycle as a 6th timeout -> timeout_cnt=0.
- Reset mid-sequence: assert rst during STABLE -> pll_rst=1, sys_rst=1, counters 0 immediately (before the next edge); after release, a full 16-cycle pll_rst pulse is observed.
